cpu_run_controller: RTL

//  Top-level run sequencer for the 5-stage pipelined RISC-V core. Starts execution after the

---
 rtl/cpu_ctrl_pkg.sv | 17 +
 rtl/sat_counter.sv | 26 ++
 rtl/cpu_run_controller.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared run-control constants: FSM state encoding and the SYSTEM opcode used as halt.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } run_state_t;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic is_halt(input logic [6:0] opcode, input logic [6:0] halt_op);
    return opcode == halt_op;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run sequencer for the pipelined core: start, host freeze, halt/limit detection,
// fixed-length pipeline drain and cycle-count readout.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int         CYCLE_W    = 32,
  parameter int         PIPE_DEPTH = 4,
  parameter int         MAX_CYCLES = 0,
  parameter logic [6:0] HALT_OP    = OPC_SYSTEM
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               host_busy,
  input  logic [31:0]        instr_id,
  output logic               cpu_enable,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [1:0]         state,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam int DRAIN_W = (PIPE_DEPTH < 1) ? 1 : $clog2(PIPE_DEPTH + 1);
  localparam logic [CYCLE_W-1:0] LIMIT_M1 =
    (MAX_CYCLES == 0) ? '0 : CYCLE_W'(MAX_CYCLES - 1);

  run_state_t         state_q;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               launch;
  logic               halt_seen;
  logic               limit_hit;

  // Only the opcode field of IF/ID matters here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_id[31:7];

  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign cpu_enable = busy & ~host_busy;
  assign state      = state_q;

  assign launch    = ~abort & start & ~host_busy &
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // IF/ID is stale while frozen, so the opcode is only trusted on enabled edges.
  assign halt_seen = cpu_enable && is_halt(instr_id[6:0], HALT_OP);
  assign limit_hit = (MAX_CYCLES != 0) && cpu_enable && (cycle_count == LIMIT_M1);

  sat_counter #(.W(CYCLE_W)) u_cycle_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .clear  (launch),
    .inc    (cpu_enable),
    .count  (cycle_count)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_IDLE;
      drain_cnt <= '0;
      timeout   <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !host_busy) begin
            state_q <= ST_RUN;
            timeout <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt_seen) begin
            state_q   <= ST_DRAIN;
            drain_cnt <= DRAIN_W'(PIPE_DEPTH);
          end else if (limit_hit) begin
            state_q   <= ST_DRAIN;
            drain_cnt <= DRAIN_W'(PIPE_DEPTH);
            timeout   <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cpu_enable) begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
            if (drain_cnt <= DRAIN_W'(1)) state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
